// File: rtl/world_map_arbiter_if.sv
// World-map RAM sharing bundle: video fetch port, bot req/ack port and the
// registered single-port RAM interface. The arbiter takes the slave view.
interface world_map_arbiter_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 2
);
  // Video scan path
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_valid;
  logic [DATA_W-1:0] vid_data;

  // Bot access
  logic              bot_req;
  logic              bot_wr;
  logic [ADDR_W-1:0] bot_addr;
  logic [DATA_W-1:0] bot_wdata;
  logic              bot_ack;
  logic [DATA_W-1:0] bot_rdata;

  // Single-port map RAM
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  vid_req, vid_addr, bot_req, bot_wr, bot_addr, bot_wdata, mem_rdata,
    output vid_valid, vid_data, bot_ack, bot_rdata, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output vid_req, vid_addr, bot_req, bot_wr, bot_addr, bot_wdata, mem_rdata,
    input  vid_valid, vid_data, bot_ack, bot_rdata, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/world_map_arbiter.sv
// Arbitrates the single-port world-map RAM between the video scan path
// (priority) and the bot. A starvation counter forces a bot slot after
// STARVE_MAX waiting cycles; the displaced video fetch goes to a 1-deep skid.
// Slot decided at E0, RAM driven at E1, RAM data at E2, result registered at E3.
// Optional feature: define WMA_BOT_WRITE_EN to let the bot write map cells.
module world_map_arbiter #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned DATA_W     = 2,
  parameter int unsigned STARVE_MAX = 32
) (
  input logic                clk,
  input logic                resetn,
  world_map_arbiter_if.slave bus
);

  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {StIdle, StVid, StBot} slot_state_e;
  typedef enum logic [1:0] {TagNone, TagVid, TagBotRd, TagBotWr} slot_tag_e;

  // Slot FSM state and registered slot request
  slot_state_e       state_q, state_d;
  logic [ADDR_W-1:0] slot_addr_q, slot_addr_d;
  logic              slot_wr_q, slot_wr_d;

  // Video skid register, bot handshake and starvation tracking
  logic              vid_pend_q, vid_pend_d;
  logic [ADDR_W-1:0] vid_pend_addr_q, vid_pend_addr_d;
  logic              bot_busy_q, bot_busy_d;
  logic [StarveW-1:0] starve_q, starve_d;

  logic vid_cand, bot_cand, force_bot, bot_wr_req;

  // RAM-side registers and per-slot owner tags through the read pipe
  logic [ADDR_W-1:0] mem_addr_q;
  slot_tag_e         slot_tag, tag1_q, tag2_q;

  // Result registers
  logic              vid_valid_q;
  logic [DATA_W-1:0] vid_data_q;
  logic              bot_ack_q;
  logic [DATA_W-1:0] bot_rdata_q;
  logic              ack_defer_q;
  logic              ack_rd, wr_done, ack_wr;

`ifdef WMA_BOT_WRITE_EN
  logic [DATA_W-1:0] slot_wdata_q, slot_wdata_d;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;

  assign bot_wr_req = bus.bot_wr;
`else
  logic unused_bot;

  assign bot_wr_req = 1'b0;
  assign unused_bot = ^{bus.bot_wr, bus.bot_wdata};
`endif

  // Slot decision: forced bot slot, else video, else bot, else idle
  always_comb begin
    vid_cand        = bus.vid_req | vid_pend_q;
    bot_cand        = bus.bot_req & ~bot_busy_q;
    force_bot       = bot_cand & (starve_q == StarveW'(STARVE_MAX));
    state_d         = StIdle;
    slot_addr_d     = slot_addr_q;
    slot_wr_d       = 1'b0;
    vid_pend_d      = vid_pend_q;
    vid_pend_addr_d = vid_pend_addr_q;
`ifdef WMA_BOT_WRITE_EN
    slot_wdata_d    = slot_wdata_q;
`endif

    if (force_bot) begin
      state_d = StBot;
      // Displaced video strobe waits one slot in the skid register
      if (bus.vid_req) begin
        vid_pend_d      = 1'b1;
        vid_pend_addr_d = bus.vid_addr;
      end
    end else if (vid_cand) begin
      state_d = StVid;
      if (vid_pend_q) begin
        // Older pending fetch goes first; a new strobe takes its place
        slot_addr_d = vid_pend_addr_q;
        vid_pend_d  = bus.vid_req;
        if (bus.vid_req) begin
          vid_pend_addr_d = bus.vid_addr;
        end
      end else begin
        slot_addr_d = bus.vid_addr;
      end
    end else if (bot_cand) begin
      state_d = StBot;
    end

    if (state_d == StBot) begin
      slot_addr_d = bus.bot_addr;
      slot_wr_d   = bot_wr_req;
`ifdef WMA_BOT_WRITE_EN
      slot_wdata_d = bus.bot_wdata;
`endif
    end

    // Busy from grant until the cycle after the ack strobe
    if (state_d == StBot) begin
      bot_busy_d = 1'b1;
    end else if (bot_ack_q) begin
      bot_busy_d = 1'b0;
    end else begin
      bot_busy_d = bot_busy_q;
    end

    if ((state_d == StBot) || !bot_cand) begin
      starve_d = '0;
    end else if (starve_q != StarveW'(STARVE_MAX)) begin
      starve_d = starve_q + StarveW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Slot FSM and its registered slot outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= StIdle;
      slot_addr_q     <= '0;
      slot_wr_q       <= 1'b0;
      vid_pend_q      <= 1'b0;
      vid_pend_addr_q <= '0;
      bot_busy_q      <= 1'b0;
      starve_q        <= '0;
`ifdef WMA_BOT_WRITE_EN
      slot_wdata_q    <= '0;
`endif
    end else begin
      state_q         <= state_d;
      slot_addr_q     <= slot_addr_d;
      slot_wr_q       <= slot_wr_d;
      vid_pend_q      <= vid_pend_d;
      vid_pend_addr_q <= vid_pend_addr_d;
      bot_busy_q      <= bot_busy_d;
      starve_q        <= starve_d;
`ifdef WMA_BOT_WRITE_EN
      slot_wdata_q    <= slot_wdata_d;
`endif
    end
  end

  // Owner tag of the slot issued at the last edge
  always_comb begin
    slot_tag = TagNone;
    unique case (state_q)
      StVid:   slot_tag = TagVid;
      StBot:   slot_tag = slot_wr_q ? TagBotWr : TagBotRd;
      default: slot_tag = TagNone;
    endcase
  end

  // Drive the RAM one cycle after the slot decision; address holds when idle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_addr_q <= '0;
      tag1_q     <= TagNone;
`ifdef WMA_BOT_WRITE_EN
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
`endif
    end else begin
      mem_addr_q <= slot_addr_q;
      tag1_q     <= slot_tag;
`ifdef WMA_BOT_WRITE_EN
      mem_we_q    <= slot_wr_q;
      mem_wdata_q <= slot_wdata_q;
`endif
    end
  end

  // A write ack colliding with a video result slips by one cycle so the two
  // strobes stay exclusive; bot_busy guarantees only one bot slot in flight.
  always_comb begin
    ack_rd  = (tag2_q == TagBotRd);
    wr_done = (tag1_q == TagBotWr);
    ack_wr  = (wr_done & (tag2_q != TagVid)) | ack_defer_q;
  end

  // Read pipe: route RAM data to the owner of the slot
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tag2_q      <= TagNone;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
      bot_ack_q   <= 1'b0;
      bot_rdata_q <= '0;
      ack_defer_q <= 1'b0;
    end else begin
      tag2_q      <= tag1_q;
      vid_valid_q <= (tag2_q == TagVid);
      if (tag2_q == TagVid) begin
        vid_data_q <= bus.mem_rdata;
      end
      bot_ack_q <= ack_rd | ack_wr;
      if (ack_rd) begin
        bot_rdata_q <= bus.mem_rdata;
      end
      ack_defer_q <= wr_done & (tag2_q == TagVid);
    end
  end

  assign bus.vid_valid = vid_valid_q;
  assign bus.vid_data  = vid_data_q;
  assign bus.bot_ack   = bot_ack_q;
  assign bus.bot_rdata = bot_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
`ifdef WMA_BOT_WRITE_EN
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
`else
  assign bus.mem_we    = 1'b0;
  assign bus.mem_wdata = '0;
`endif

endmodule

// File: tb/tb_world_map_arbiter.sv
// Scoreboard bench for world_map_arbiter: stimulus pushes expected results with
// their due cycle, a negedge monitor pops and compares on vid_valid/bot_ack.
module tb_world_map_arbiter;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 2;

  typedef struct {
    int unsigned due;
    logic [1:0]  data;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned we_cnt = 0;
  logic [13:0] we_addr = '0;
  logic [1:0]  we_data = '0;
  exp_t        vid_q[$];
  exp_t        bot_q[$];
  exp_t        mon_e;

  logic [1:0] ram [16384];
  bit         wr_mask [16384];

  always #5 clk = ~clk;

  world_map_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  world_map_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_MAX(32)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Power-on map contents: a few hand-placed cells, a simple pattern elsewhere
  function automatic logic [1:0] init_cell(input logic [13:0] a);
    if (a == 14'h0123) return 2'b10;
    if (a == 14'h3FFF) return 2'b01;
    if (a == 14'h0040) return 2'b00;
    return a[1:0] ^ a[3:2];
  endfunction

  // Synchronous single-port RAM, read-before-write
  always @(posedge clk) begin
    if (wr_mask[bus.mem_addr]) bus.mem_rdata <= ram[bus.mem_addr];
    else bus.mem_rdata <= init_cell(bus.mem_addr);
    if (bus.mem_we) begin
      ram[bus.mem_addr]     <= bus.mem_wdata;
      wr_mask[bus.mem_addr] <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pop and compare whenever the DUT presents a result
  always @(negedge clk) begin
    if (bus.vid_valid && bus.bot_ack) check("vid_bot_exclusive", 32'd1, 32'd0);
    if (bus.vid_valid) begin
      if (vid_q.size() == 0) begin
        check("vid_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = vid_q.pop_front();
        check("vid_data", 32'(bus.vid_data), 32'(mon_e.data));
        check("vid_latency", cyc, mon_e.due);
      end
    end
    if (bus.bot_ack) begin
      if (bot_q.size() == 0) begin
        check("bot_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = bot_q.pop_front();
        check("bot_rdata", 32'(bus.bot_rdata), 32'(mon_e.data));
        check("bot_latency", cyc, mon_e.due);
      end
    end
    if (bus.mem_we) begin
      we_cnt++;
      we_addr = bus.mem_addr;
      we_data = bus.mem_wdata;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_vid_valid"}, 32'(bus.vid_valid), 32'd0);
    check({tag, "_vid_data"},  32'(bus.vid_data),  32'd0);
    check({tag, "_bot_ack"},   32'(bus.bot_ack),   32'd0);
    check({tag, "_bot_rdata"}, 32'(bus.bot_rdata), 32'd0);
    check({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    check({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
    check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
  endtask

  // One video strobe; lat counts from the sampling edge
  task automatic vid_one(input logic [13:0] a, input logic [1:0] exp, input int unsigned lat);
    exp_t e;
    @(posedge clk); #1;
    bus.vid_req  = 1'b1;
    bus.vid_addr = a;
    e.due = cyc + 1 + lat;
    e.data = exp;
    vid_q.push_back(e);
    @(posedge clk); #1;
    bus.vid_req = 1'b0;
  endtask

  // Strobes at base+i every `spacing` cycles; from force_idx on, latency is 4
  task automatic vid_stream(input logic [13:0] base, input int count, input int spacing,
                            input int force_idx);
    exp_t e;
    for (int i = 0; i < count; i++) begin
      @(posedge clk); #1;
      bus.vid_req  = 1'b1;
      bus.vid_addr = base + 14'(i);
      e.due = cyc + 1 + ((i >= force_idx) ? 4 : 3);
      e.data = init_cell(base + 14'(i));
      vid_q.push_back(e);
      if (spacing == 2) begin
        @(posedge clk); #1;
        bus.vid_req = 1'b0;
      end
    end
    @(posedge clk); #1;
    bus.vid_req = 1'b0;
  endtask

  // Bot access; req stays high through the ack cycle, then drops
  task automatic bot_access(input logic [13:0] a, input logic wr, input logic [1:0] wd,
                            input logic [1:0] exp, input int unsigned lat);
    exp_t e;
    bit   got;
    @(posedge clk); #1;
    bus.bot_req   = 1'b1;
    bus.bot_wr    = wr;
    bus.bot_addr  = a;
    bus.bot_wdata = wd;
    e.due = cyc + 1 + lat;
    e.data = exp;
    bot_q.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (bus.bot_ack) got = 1'b1;
    end
    if (!got) check("bot_ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.bot_req = 1'b0;
    bus.bot_wr  = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 100 && (vid_q.size() != 0 || bot_q.size() != 0); k++) @(negedge clk);
    check({tag, "_drained"}, 32'(vid_q.size() + bot_q.size()), 32'd0);
    repeat (6) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.vid_req   = 1'b0;
    bus.vid_addr  = '0;
    bus.bot_req   = 1'b0;
    bus.bot_wr    = 1'b0;
    bus.bot_addr  = '0;
    bus.bot_wdata = '0;

    // Power-on reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("rst_init");
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (3) @(posedge clk);

    // Test 2: single video fetch
    vid_one(14'h0123, 2'b10, 3);
    drain("t2");

    // Test 1: reset for 2 cycles with a bot read and a video fetch in flight
    @(posedge clk); #1;
    bus.bot_req  = 1'b1;
    bus.bot_addr = 14'h3FFF;
    @(posedge clk); #1;
    bus.vid_req  = 1'b1;
    bus.vid_addr = 14'h0123;
    @(posedge clk); #1;
    bus.vid_req = 1'b0;
    bus.bot_req = 1'b0;
    resetn      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero("rst_mid_a");
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check_zero("rst_mid_b");
    repeat (10) @(posedge clk);

    // Test 3: bot read, req held through the ack cycle must not re-grant
    bot_access(14'h3FFF, 1'b0, 2'b00, 2'b01, 3);
    drain("t3");

    // Test 4a: strobes every 2 cycles, bot takes the first free slot
    fork
      bot_access(14'h0207, 1'b0, 2'b00, 2'b10, 4);
      vid_stream(14'h1000, 8, 2, 1000);
    join
    drain("t4a");

    // Test 4b: continuous video, bot forced in after 32 waiting cycles
    fork
      bot_access(14'h0209, 1'b0, 2'b00, 2'b11, 35);
      vid_stream(14'h1100, 40, 1, 32);
    join
    drain("t4b");

    // Test 5: simultaneous requests, video first then bot
    fork
      vid_one(14'h0123, 2'b10, 3);
      bot_access(14'h3FFF, 1'b0, 2'b00, 2'b01, 4);
    join
    drain("t5");

    // Test 6: bot write, then video read-back
`ifdef WMA_BOT_WRITE_EN
    bot_access(14'h0040, 1'b1, 2'b11, 2'b01, 2);
    drain("t6w");
    vid_one(14'h0040, 2'b11, 3);
    drain("t6r");
    check("mem_we_pulses", we_cnt, 32'd1);
    check("mem_we_addr", 32'(we_addr), 32'h0040);
    check("mem_we_data", 32'(we_data), 32'd3);
`else
    bot_access(14'h0040, 1'b1, 2'b11, 2'b00, 3);
    drain("t6w");
    vid_one(14'h0040, 2'b00, 3);
    drain("t6r");
    check("mem_we_never", we_cnt, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
